alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Upstream feeder for the combinational 8-bit ALU: buffers operation requests (A, B, opcode) in a small FIFO.
- Presents one request at a time on registered ALU operand/select outputs and captures the 9-bit ALU result one cycle later.
- Returns the result on a valid/ready output channel, decoupling the request producer from the result consumer.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- DATA_W, 8, operand width; the result width is DATA_W+1.
- SEL_W, 4, ALU opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  queue can accept a request.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_sel  in  SEL_W  ALU opcode.
- alu_a  out  DATA_W  registered operand A to the ALU.
- alu_b  out  DATA_W  registered operand B to the ALU.
- alu_sel  out  SEL_W  registered opcode to the ALU.
- alu_result  in  DATA_W+1  combinational result from the ALU.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W+1  captured result.
- out_sel  out  SEL_W  opcode that produced out_result.
- count  out  clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO emptied, pointers cleared, count=0, FSM=IDLE.
  - alu_a, alu_b, alu_sel, out_result and out_sel all 0; out_valid=0.
  - in_ready=1 after release.
  - Reset mid-operation discards all queued and in-flight ops; no result is emitted for them.
- Push and flow control:
  - A push occurs on a clk edge with in_valid && in_ready.
  - in_ready = (count < DEPTH), purely combinational from registered count.
  - When full, in_ready=0, even if a pop occurs in the same cycle.
- Pointers: wrap modulo DEPTH. count is updated +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if count>0, pop the head into alu_a/alu_b/alu_sel, go to EXEC; otherwise stay.
  - EXEC: the ALU has had one full cycle to settle. Capture alu_result into out_result and alu_sel into out_sel, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1; out_result and out_sel are held stable.
    - out_ready=0: stay.
    - out_ready=1 and count>0: clear out_valid, pop the next head into the ALU registers, go to EXEC.
    - out_ready=1 and count=0: clear out_valid, go to IDLE.
- ALU operand registers: hold their last value when not loading (no return to 0).
- Latency and throughput:
  - Request accepted at edge N into an empty idle queue: popped at N+1, out_valid high after N+2.
  - Sustained throughput is one result per 2 cycles with out_ready held high.
- Ordering and arithmetic:
  - Results emerge in strict request order; no reordering or dropping.
  - Result width is DATA_W+1, carried unmodified from the ALU.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured.
  - A push into an empty FIFO is not visible to IDLE until the following edge.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined: in IDLE with count=0 and in_valid=1, the request is loaded directly into alu_a/alu_b/alu_sel at the accepting edge, without being written to the FIFO; FSM goes to EXEC.
  - count stays 0.
  - out_valid is high one cycle after acceptance.
  - Applies only in IDLE with an empty FIFO.
- Undefined: every request passes through the FIFO; latency is 2 cycles as above.

Test Plan:
1. Reset, then single add: in_sel=0, A=255, B=0 -> alu_a=255 one edge after accept; out_valid after 2 edges (1 with BYPASS); out_result=255; out_sel=0.
2. Three back-to-back adds, out_ready=1 -> results 255, 255 and 510, in order from requests (255,0), (240,15) and (255,255); one result every 2 cycles; 510 uses the 9th bit.
3. Full and backpressure: out_ready=0, push 5 requests -> first request in HOLD, the next 4 fill the FIFO (count=4, in_ready=0); the sixth in_valid is not accepted; raise out_ready -> all 5 results in order, and in_ready rises the cycle after the first pop.
4. Hold stability: out_ready=0 for 10 cycles while in HOLD -> out_result, out_sel and out_valid are unchanged every cycle.
5. Simultaneous push and pop with count=2 -> count remains 2; pointer wrap verified after 2*DEPTH ops with matching data.
6. Assert rst_n=0 during EXEC with 3 queued -> outputs 0 immediately (asynchronous), count=0, no stale result after release; a new request (240,15) -> 255.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Request FIFO and issue FSM that feeds a combinational ALU and returns its result on a valid/ready channel.
// Define ALU_ISSUE_BYPASS_EN to let an idle, empty queue load a request straight into the ALU registers.
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic [SEL_W-1:0]           in_sel,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [SEL_W-1:0]           alu_sel,
  input  logic [DATA_W:0]            alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W:0]            out_result,
  output logic [SEL_W-1:0]           out_sel,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [DATA_W-1:0] memA_q   [DEPTH];
  logic [DATA_W-1:0] memB_q   [DEPTH];
  logic [SEL_W-1:0]  memSel_q [DEPTH];

  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;

  logic [DATA_W-1:0] aluA_q, aluA_d;
  logic [DATA_W-1:0] aluB_q, aluB_d;
  logic [SEL_W-1:0]  aluSel_q, aluSel_d;
  logic [DATA_W:0]   outResult_q, outResult_d;
  logic [SEL_W-1:0]  outSel_q, outSel_d;
  logic              outValid_q, outValid_d;

  logic              pushReq;
  logic              pushFifo;
  logic              popFifo;
  logic              bypassTake;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign pushReq  = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypassTake = (state_q == IDLE) && (count_q == '0) && in_valid;
`else
  assign bypassTake = 1'b0;
`endif

  // A bypassed request goes straight to the ALU registers and never occupies a slot.
  assign pushFifo = pushReq && !bypassTake;

  always_comb begin
    state_d     = state_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    aluSel_d    = aluSel_q;
    outResult_d = outResult_q;
    outSel_d    = outSel_q;
    outValid_d  = outValid_q;
    popFifo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bypassTake) begin
          aluA_d   = in_a;
          aluB_d   = in_b;
          aluSel_d = in_sel;
          state_d  = EXEC;
        end else if (count_q != '0) begin
          popFifo  = 1'b1;
          aluA_d   = memA_q[rdPtr_q];
          aluB_d   = memB_q[rdPtr_q];
          aluSel_d = memSel_q[rdPtr_q];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        outResult_d = alu_result;
        outSel_d    = aluSel_q;
        outValid_d  = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          if (count_q != '0) begin
            popFifo  = 1'b1;
            aluA_d   = memA_q[rdPtr_q];
            aluB_d   = memB_q[rdPtr_q];
            aluSel_d = memSel_q[rdPtr_q];
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({pushFifo, popFifo})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pushFifo) begin
      memA_q[wrPtr_q]   <= in_a;
      memB_q[wrPtr_q]   <= in_b;
      memSel_q[wrPtr_q] <= in_sel;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluSel_q    <= '0;
      outResult_q <= '0;
      outSel_q    <= '0;
      outValid_q  <= 1'b0;
    end else begin
      if (pushFifo) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (popFifo)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      aluSel_q    <= aluSel_d;
      outResult_q <= outResult_d;
      outSel_q    <= outSel_d;
      outValid_q  <= outValid_d;
    end
  end

  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_sel    = aluSel_q;
  assign out_valid  = outValid_q;
  assign out_result = outResult_q;
  assign out_sel    = outSel_q;
  assign count      = count_q;

  countBounded: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));

  holdStable: assert property (@(posedge clk) disable iff (!rst_n)
    (outValid_q && !out_ready) |=> (outValid_q && $stable(outResult_q) && $stable(outSel_q)));

endmodule
